// File: rtl/rf_write_scheduler_if.sv
// rf_write_scheduler_if: bundles the writeback, long-latency, issue/query and
// register-file write-port signals of the write scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface rf_write_scheduler_if;
    // Writeback stage
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;

    // Long-latency unit
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;

    // Issue and hazard query
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic [4:0]  q_rd;
    logic        hazard;

    // Register-file write port
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        output wb_stall,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        input  iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
        output hazard,
        output rf_we, rf_rd, rf_wdata
    );

    modport master (
        output wb_valid, wb_rd, wb_data,
        input  wb_stall,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        output iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
        input  hazard,
        input  rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: arbitrates the single register-file write port between
// the in-order writeback stage and one long-latency result unit, and keeps a
// scoreboard of destination registers still owed by the long-latency unit.
// Long-latency results always pass through a one-entry hold register; a held
// result blocked by writeback for MAX_WAIT cycles forces a one-cycle wb_stall.
module rf_write_scheduler #(
    parameter int unsigned MAX_WAIT = 4   // legal range 1..15
) (
    input logic              clk,
    input logic              rst,
    rf_write_scheduler_if.slave bus
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic        hv;
    logic [4:0]  h_rd;
    logic [31:0] h_data;
    logic [3:0]  wcnt;
    logic [31:0] pending;
    logic [31:0] pending_next;

    logic        stall;
    logic        wb_win;
    logic        drain;
    logic        ready;
    logic        accept;
    logic        iss_set;

    logic        we_q;
    logic [4:0]  rd_q;
    logic [31:0] wdata_q;

    // Arbitration: the held result is forced through once it has waited
    // MAX_WAIT cycles; stall depends on registers only, so it never loops
    // back through the writeback stage combinationally.
    assign stall   = hv && (wcnt == WAIT_LIMIT);
    assign wb_win  = bus.wb_valid && !stall;
    assign drain   = hv && !wb_win;          // hv & (!wb_valid | wb_stall)
    assign ready   = !hv || drain;           // hold is empty or empties this edge
    assign accept  = bus.lu_valid && ready;
    assign iss_set = bus.iss_valid && (bus.iss_rd != 5'd0);

    assign bus.wb_stall = stall;
    assign bus.lu_ready = ready;
    assign bus.hazard   = pending[bus.q_rs1] | pending[bus.q_rs2] | pending[bus.q_rd];
    assign bus.rf_we    = we_q;
    assign bus.rf_rd    = rd_q;
    assign bus.rf_wdata = wdata_q;

    // Hold-register valid bit: a refill on the drain edge keeps it set.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hv <= 1'b0;
        end else if (accept) begin
            hv <= 1'b1;
        end else if (drain) begin
            hv <= 1'b0;
        end
    end

    // Hold-register payload, loaded on every accepted long-latency result.
    // NOTE: the payload has no reset; hv qualifies it, so a reset value would
    // only cost reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (accept) begin
            h_rd   <= bus.lu_rd;
            h_data <= bus.lu_data;
        end
    end

    // Wait counter: counts cycles the held result loses to writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 4'd0;
        end else if (!hv || drain) begin
            wcnt <= 4'd0;
        end else if (wcnt != WAIT_LIMIT) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Registered write port: writeback first, then the held result; an x0
    // destination consumes the source but suppresses the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            rd_q    <= 5'd0;
            wdata_q <= 32'd0;
        end else if (wb_win) begin
            we_q    <= (bus.wb_rd != 5'd0);
            rd_q    <= bus.wb_rd;
            wdata_q <= bus.wb_data;
        end else if (hv) begin
            we_q    <= (h_rd != 5'd0);
            rd_q    <= h_rd;
            wdata_q <= h_data;
        end else begin
            we_q    <= 1'b0;
        end
    end

    // Scoreboard next state: clear on drain, then set on issue so set wins.
    // NOTE: pending_next gets a full default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pending_next = pending;
        if (drain) begin
            pending_next[h_rd] = 1'b0;
        end
        if (iss_set) begin
            pending_next[bus.iss_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb_rf_write_scheduler: directed scenarios plus a randomized run checked
// cycle by cycle against a behavioural model of the write scheduler.
module tb_rf_write_scheduler;

    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    rf_write_scheduler_if bus();

    rf_write_scheduler #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Held result: valid flag, destination, data, and how many cycles it has
    // already been blocked by writeback. Scoreboard as a plain bit array.
    bit          m_hv;
    logic [4:0]  m_hrd;
    logic [31:0] m_hdata;
    int unsigned m_age;
    bit          m_pend [32];
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;

    task automatic model_reset();
        m_hv = 0; m_hrd = '0; m_hdata = '0; m_age = 0;
        m_we = 0; m_rd = '0; m_wdata = '0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    function automatic bit m_stall();
        return m_hv && (m_age == MAX_WAIT);
    endfunction

    // The hold slot can take a new result if it is free or leaves this cycle.
    function automatic bit m_ready();
        return !m_hv || !bus.wb_valid || m_stall();
    endfunction

    function automatic bit m_hazard();
        return m_pend[bus.q_rs1] || m_pend[bus.q_rs2] || m_pend[bus.q_rd];
    endfunction

    task automatic model_advance();
        bit wb_wins, drained, taken;
        wb_wins = bus.wb_valid && !m_stall();
        drained = m_hv && !wb_wins;
        taken   = bus.lu_valid && m_ready();
        if (wb_wins) begin
            m_we = (bus.wb_rd != 0); m_rd = bus.wb_rd; m_wdata = bus.wb_data;
        end else if (m_hv) begin
            m_we = (m_hrd != 0); m_rd = m_hrd; m_wdata = m_hdata;
        end else begin
            m_we = 0;
        end
        m_age = (m_hv && wb_wins) ? m_age + 1 : 0;
        if (drained) m_pend[m_hrd] = 0;
        if (bus.iss_valid && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1;
        if (taken) begin
            m_hv = 1; m_hrd = bus.lu_rd; m_hdata = bus.lu_data;
        end else if (drained) begin
            m_hv = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.lu_valid = 0; bus.lu_rd = '0; bus.lu_data = '0;
        bus.iss_valid = 0; bus.iss_rd = '0;
        bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
    endtask

    // One clock: the model consumes the current inputs, then wait for the
    // next falling edge where the following cycle's inputs are applied.
    task automatic step();
        model_advance();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        bus.q_rs1 = 5'd1; bus.q_rs2 = 5'd2; bus.q_rd = 5'd3;
        #1;
        tests_run++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== 38'd0) begin
            tests_failed++;
            $display("FAIL reset_port: got we=%b rd=%0d data=%h, expected all zero",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        tests_run++;
        if ({bus.wb_stall, bus.lu_ready, bus.hazard} !== 3'b010) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got stall=%b ready=%b hazard=%b, expected 0 1 0",
                     bus.wb_stall, bus.lu_ready, bus.hazard);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_writeback_only();
        bus.wb_valid = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        step();
        bus.wb_rd = 5'd0; bus.wb_data = 32'h0BADF00D;
        #1;
        tests_run++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL wb_write: got we=%b rd=%0d data=%h, expected we=1 rd=5 data=deadbeef",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        step();
        bus.wb_valid = 0;
        #1;
        tests_run++;
        if (bus.rf_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL wb_x0: got we=%b, expected we=0", bus.rf_we);
        end
        step();
        #1;
        tests_run++;
        if (bus.rf_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL wb_idle: got we=%b, expected we=0", bus.rf_we);
        end
    endtask

    task automatic test_lu_idle_path();
        bus.iss_valid = 1; bus.iss_rd = 5'd7;
        step();
        bus.iss_valid = 0; bus.q_rd = 5'd7;
        #1;
        tests_run++;
        if (bus.hazard !== 1'b1) begin
            tests_failed++;
            $display("FAIL hazard_q_rd: got %b, expected 1", bus.hazard);
        end
        bus.q_rd = 5'd0; bus.q_rs1 = 5'd7;
        bus.lu_valid = 1; bus.lu_rd = 5'd7; bus.lu_data = 32'h12;
        #1;
        tests_run++;
        if ({bus.hazard, bus.lu_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL lu_offer: got hazard=%b ready=%b, expected 1 1", bus.hazard, bus.lu_ready);
        end
        step();
        bus.lu_valid = 0;
        #1;
        tests_run++;
        if ({bus.hazard, bus.rf_we} !== 2'b10) begin
            tests_failed++;
            $display("FAIL lu_held: got hazard=%b we=%b, expected 1 0", bus.hazard, bus.rf_we);
        end
        step();
        #1;
        tests_run++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.hazard} !== {1'b1, 5'd7, 32'h12, 1'b0}) begin
            tests_failed++;
            $display("FAIL lu_write: got we=%b rd=%0d data=%h hazard=%b, expected 1 7 12 0",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.hazard);
        end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_data [1:7];
        logic [4:0]  exp_rd;
        int k;
        exp_data[1] = 32'h100; exp_data[2] = 32'h101; exp_data[3] = 32'h102;
        exp_data[4] = 32'h103; exp_data[5] = 32'h104; exp_data[6] = 32'hA5A5;
        exp_data[7] = 32'h105;
        bus.wb_valid = 1; bus.wb_rd = 5'd1; bus.wb_data = 32'h100;
        bus.lu_valid = 1; bus.lu_rd = 5'd12; bus.lu_data = 32'hA5A5;
        step();
        bus.lu_valid = 0;
        k = 1;
        for (int c = 1; c <= 7; c++) begin
            bus.wb_data = 32'h100 + 32'(k);
            #1;
            exp_rd = (c == 6) ? 5'd12 : 5'd1;
            tests_run++;
            if (bus.wb_stall !== (c == 5)) begin
                tests_failed++;
                $display("FAIL starve_stall c%0d: got %b, expected %b", c, bus.wb_stall, (c == 5));
            end
            tests_run++;
            if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, exp_rd, exp_data[c]}) begin
                tests_failed++;
                $display("FAIL starve_port c%0d: got we=%b rd=%0d data=%h, expected 1 %0d %h",
                         c, bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_rd, exp_data[c]);
            end
            if (c != 5) k++;
            step();
        end
        bus.wb_valid = 0;
        #1;
        tests_run++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd1, 32'h106}) begin
            tests_failed++;
            $display("FAIL starve_last: got we=%b rd=%0d data=%h, expected 1 1 106",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 5; c++) begin
            bus.lu_valid = (c <= 2);
            bus.lu_rd    = 5'(20 + c);
            bus.lu_data  = 32'hB000 + 32'(c);
            #1;
            if (c <= 2) begin
                tests_run++;
                if (bus.lu_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_ready c%0d: got %b, expected 1", c, bus.lu_ready);
                end
            end
            if (c >= 2 && c <= 4) begin
                tests_run++;
                if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'(18 + c), 32'hB000 + 32'(c - 2)}) begin
                    tests_failed++;
                    $display("FAIL b2b_port c%0d: got we=%b rd=%0d data=%h, expected 1 %0d %h",
                             c, bus.rf_we, bus.rf_rd, bus.rf_wdata, 18 + c, 32'hB000 + 32'(c - 2));
                end
            end
            if (c == 5) begin
                tests_run++;
                if (bus.rf_we !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_done: got we=%b, expected 0", bus.rf_we);
                end
            end
            step();
        end
    endtask

    task automatic test_set_wins();
        bus.iss_valid = 1; bus.iss_rd = 5'd9;
        bus.lu_valid = 1; bus.lu_rd = 5'd9; bus.lu_data = 32'h99;
        step();
        bus.lu_valid = 0;           // hold drains r9 while r9 is issued again
        step();
        bus.iss_valid = 0; bus.q_rs2 = 5'd9;
        #1;
        tests_run++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.hazard} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
            tests_failed++;
            $display("FAIL set_wins: got we=%b rd=%0d data=%h hazard=%b, expected 1 9 99 1",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.hazard);
        end
        step();
        #1;
        tests_run++;
        if (bus.hazard !== 1'b1) begin
            tests_failed++;
            $display("FAIL set_wins_hold: got hazard=%b, expected 1", bus.hazard);
        end
    endtask

    task automatic test_mid_reset();
        bus.iss_valid = 1; bus.iss_rd = 5'd3;
        bus.lu_valid = 1; bus.lu_rd = 5'd3; bus.lu_data = 32'h33;
        bus.wb_valid = 1; bus.wb_rd = 5'd2; bus.wb_data = 32'h22;
        step();
        bus.iss_valid = 0; bus.lu_valid = 0; bus.q_rs1 = 5'd3;
        #1;
        tests_run++;
        if ({bus.rf_we, bus.hazard, bus.lu_ready} !== 3'b110) begin
            tests_failed++;
            $display("FAIL mid_pre: got we=%b hazard=%b ready=%b, expected 1 1 0",
                     bus.rf_we, bus.hazard, bus.lu_ready);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.rf_we, bus.hazard, bus.lu_ready, bus.wb_stall} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL mid_reset: got we=%b hazard=%b ready=%b stall=%b, expected 0 0 1 0",
                     bus.rf_we, bus.hazard, bus.lu_ready, bus.wb_stall);
        end
        bus.wb_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            tests_run++;
            if ({bus.rf_we, bus.hazard} !== 2'b00) begin
                tests_failed++;
                $display("FAIL mid_after c%0d: got we=%b hazard=%b, expected 0 0", c, bus.rf_we, bus.hazard);
            end
        end
    endtask

    task automatic test_random();
        bit keep_wb, keep_lu, e_stall, e_ready, e_haz;
        apply_reset();
        keep_wb = 0;
        keep_lu = 0;
        for (int c = 0; c < 600; c++) begin
            if (!keep_wb) begin
                bus.wb_valid = ($urandom_range(0, 99) < 65);
                bus.wb_rd    = 5'($urandom_range(0, 31));
                bus.wb_data  = $urandom;
            end
            if (!keep_lu) begin
                bus.lu_valid = ($urandom_range(0, 99) < 45);
                bus.lu_rd    = 5'($urandom_range(0, 31));
                bus.lu_data  = $urandom;
            end
            bus.iss_valid = ($urandom_range(0, 99) < 30);
            bus.iss_rd    = 5'($urandom_range(0, 31));
            bus.q_rs1     = 5'($urandom_range(0, 31));
            bus.q_rs2     = 5'($urandom_range(0, 31));
            bus.q_rd      = 5'($urandom_range(0, 31));
            #1;
            e_stall = m_stall();
            e_ready = m_ready();
            e_haz   = m_hazard();
            tests_run++;
            if ({bus.wb_stall, bus.lu_ready, bus.hazard} !== {e_stall, e_ready, e_haz}) begin
                tests_failed++;
                $display("FAIL rand_ctrl c%0d: got stall=%b ready=%b hazard=%b, expected %b %b %b",
                         c, bus.wb_stall, bus.lu_ready, bus.hazard, e_stall, e_ready, e_haz);
            end
            tests_run++;
            if (bus.rf_we !== m_we || (m_we && {bus.rf_rd, bus.rf_wdata} !== {m_rd, m_wdata})) begin
                tests_failed++;
                $display("FAIL rand_port c%0d: got we=%b rd=%0d data=%h, expected %b %0d %h",
                         c, bus.rf_we, bus.rf_rd, bus.rf_wdata, m_we, m_rd, m_wdata);
            end
            keep_wb = bus.wb_valid && e_stall;
            keep_lu = bus.lu_valid && !e_ready;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        test_reset();
        apply_reset();
        test_writeback_only();
        apply_reset();
        test_lu_idle_path();
        apply_reset();
        test_starvation();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_set_wins();
        apply_reset();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
